// File: rtl/serial_word_deframer_if.sv
// serial_word_deframer_if
//   Bundles the serial input side (bit_i/bit_valid_i), the valid/ready word
//   output, and the status/control signals of the serial word deframer.
//   Modports:
//     slave  - the deframer: consumes bits, ready_i, clear_i; drives the word,
//              flags and frame counter.
//     master - the surroundings (upstream bit source plus downstream sink).
//   Signals:
//     bit_i, bit_valid_i      serial bit and its qualifier
//     data_o [WIDTH], valid_o assembled word and its valid flag
//     ready_i                 downstream accept
//     parity_err_o            even-parity failure for the presented word
//     overflow_o, clear_i     sticky dropped-word flag and its clear
//     frame_count_o [16]      accepted-word counter
interface serial_word_deframer_if #(
  parameter int WIDTH = 8
);
  logic             bit_i;
  logic             bit_valid_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             parity_err_o;
  logic             overflow_o;
  logic             clear_i;
  logic [15:0]      frame_count_o;

  modport slave (
    input  bit_i, bit_valid_i, ready_i, clear_i,
    output data_o, valid_o, parity_err_o, overflow_o, frame_count_o
  );

  modport master (
    output bit_i, bit_valid_i, ready_i, clear_i,
    input  data_o, valid_o, parity_err_o, overflow_o, frame_count_o
  );
endinterface

// File: rtl/serial_word_deframer.sv
// serial_word_deframer
//   Hunts the retimed serial stream for SYNC_PATTERN, then assembles WIDTH
//   data bits (MSB first) and one even-parity bit into a word held in a
//   one-entry valid/ready output register. Words completing while the holding
//   register is full and not being emptied are dropped and flag overflow_o.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - serial_word_deframer_if.slave (bits in, word/flags/count out)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_HUNT   | shifting valid bits into the sync history, looking for sync
//   S_DATA   | collecting WIDTH data bits, MSB first
//   S_PARITY | next valid bit is the parity bit; word completes on it
module serial_word_deframer #(
  parameter int                  WIDTH        = 8,
  parameter int                  SYNC_LEN     = 3,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 3'b110
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_deframer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_PARITY
  } state_t;

  state_t              r_state;
  logic [SYNC_LEN-1:0] r_hist;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_shift;
  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic                r_perr;
  logic                r_ovf;
  logic [15:0]         r_frame_count;

  logic [SYNC_LEN-1:0] w_hist_next;
  logic                w_accept;
  logic                w_complete;
  logic                w_load;
  logic                w_drop;
  logic                w_parity;

  assign w_hist_next = {r_hist[SYNC_LEN-2:0], bus.bit_i};
  assign w_accept    = r_valid && bus.ready_i;
  assign w_complete  = (r_state == S_PARITY) && bus.bit_valid_i;
  // A slot being emptied on this edge can take the completing word.
  assign w_load      = w_complete && (!r_valid || w_accept);
  assign w_drop      = w_complete && r_valid && !w_accept;
  // Nonzero XOR over data plus parity bit means even parity was violated.
  assign w_parity    = ^{r_shift, bus.bit_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HUNT;
      r_hist        <= '0;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_perr        <= 1'b0;
      r_ovf         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (bus.bit_valid_i) begin
        case (r_state)
          S_HUNT: begin
            r_hist <= w_hist_next;
            if (w_hist_next == SYNC_PATTERN) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_shift[WIDTH-2:0], bus.bit_i};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            // History restarts empty so sync never overlaps frame bits.
            r_state <= S_HUNT;
            r_hist  <= '0;
          end
          default: r_state <= S_HUNT;
        endcase
      end

      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= w_parity;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      // A drop on the same edge wins over a clear request.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clear_i) begin
        r_ovf <= 1'b0;
      end

      if (w_accept) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.data_o        = r_data;
  assign bus.valid_o       = r_valid;
  assign bus.parity_err_o  = r_perr;
  assign bus.overflow_o    = r_ovf;
  assign bus.frame_count_o = r_frame_count;

endmodule

// File: tb/tb_serial_word_deframer.sv
// tb_serial_word_deframer
//   Drives directed and random serial streams into serial_word_deframer.
//   A reference model parses the valid-bit stream into frames using queues
//   and tracks a one-slot holding buffer; words it expects to be presented
//   go into a scoreboard queue that an independent monitor pops on each
//   handshake.
module tb_serial_word_deframer;
  localparam int W  = 8;
  localparam int SL = 3;
  localparam logic [SL-1:0] SP = 3'b110;

  typedef struct packed {
    logic [W-1:0] d;
    logic         pe;
  } exp_t;

  logic clk;
  logic rst;

  serial_word_deframer_if #(.WIDTH(W)) bus ();

  serial_word_deframer #(
    .WIDTH(W), .SYNC_LEN(SL), .SYNC_PATTERN(SP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sbq[$];
  logic [15:0] mon_cnt = 16'd0;

  // reference model state
  bit hq[$];
  bit fq[$];
  bit m_collect = 1'b0;
  bit m_full = 1'b0;
  bit m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sync_seen();
    logic [SL-1:0] p;
    int idx;
    bit v;
    p = SP;
    for (int k = 0; k < SL; k++) begin
      idx = hq.size() - SL + k;
      v = (idx >= 0) ? hq[idx] : 1'b0;
      if (v != p[SL-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_bit(input bit b, output bit done, output logic [W-1:0] word, output bit perr);
    int ones;
    done = 1'b0; word = '0; perr = 1'b0;
    if (!m_collect) begin
      hq.push_back(b);
      if (sync_seen()) begin
        m_collect = 1'b1;
        fq.delete();
      end
    end else begin
      fq.push_back(b);
      if (fq.size() == W + 1) begin
        ones = 0;
        for (int i = 0; i < W; i++) word = {word[W-2:0], fq[i]};
        for (int i = 0; i <= W; i++) ones += int'(fq[i]);
        perr = (ones % 2) != 0;
        done = 1'b1;
        m_collect = 1'b0;
        hq.delete();
      end
    end
  endtask

  // One clock: apply inputs, predict the edge, then check after it.
  task automatic cyc(input bit bv, input bit b, input bit rdy, input bit clr);
    bit done, pe, acc, drop;
    logic [W-1:0] w;
    bus.bit_valid_i = bv;
    bus.bit_i       = b;
    bus.ready_i     = rdy;
    bus.clear_i     = clr;
    acc  = m_full && rdy;
    done = 1'b0; drop = 1'b0; pe = 1'b0; w = '0;
    if (bv) model_bit(b, done, w, pe);
    if (done) begin
      if (!m_full || acc) begin
        sbq.push_back('{d: w, pe: pe});
        m_full = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (acc) begin
      m_full = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_o", 32'(bus.valid_o), 32'(m_full));
    chk("overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
    chk("frame_count_o", 32'(bus.frame_count_o), 32'(mon_cnt));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rdy, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit pbit, input int gap,
                            input bit rdy, input bit rdy_last);
    bit bits[$];
    logic [SL-1:0] p;
    p = SP;
    for (int i = SL - 1; i >= 0; i--) bits.push_back(p[i]);
    for (int i = W - 1; i >= 0; i--) bits.push_back(d[i]);
    bits.push_back(pbit);
    for (int i = 0; i < bits.size(); i++) begin
      cyc(1'b1, bits[i], (i == bits.size() - 1) ? rdy_last : rdy, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b1, rdy, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_o"}, 32'(bus.data_o), 32'd0);
    chk({tag, "_valid_o"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_parity_err_o"}, 32'(bus.parity_err_o), 32'd0);
    chk({tag, "_overflow_o"}, 32'(bus.overflow_o), 32'd0);
    chk({tag, "_frame_count_o"}, 32'(bus.frame_count_o), 32'd0);
  endtask

  task automatic model_reset();
    hq.delete(); fq.delete(); sbq.delete();
    m_collect = 1'b0; m_full = 1'b0; m_ovf = 1'b0;
    mon_cnt = 16'd0;
  endtask

  // Monitor: every handshake pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", bus.data_o, $time);
      end else begin
        e = sbq.pop_front();
        chk("data_o", 32'(bus.data_o), 32'(e.d));
        chk("parity_err_o", 32'(bus.parity_err_o), 32'(e.pe));
      end
      mon_cnt = mon_cnt + 16'd1;
    end
  end

  initial begin
    bit bits[$];
    logic [W-1:0] d;
    logic [SL-1:0] p;
    bit pb, rdy;
    int nidle, ngap;
    int idle_bits[6];

    rst = 1'b1;
    bus.bit_i = 1'b0; bus.bit_valid_i = 1'b0; bus.ready_i = 1'b0; bus.clear_i = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic frame and parity error
    send_frame(8'hA5, 1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // hunt with noise and gaps between every bit
    idle_bits = '{0, 1, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, idle_bits[i][0], 1'b1, 1'b0);
      idle(2, 1'b1);
    end
    send_frame(8'h3C, 1'b0, 2, 1'b1, 1'b1);
    idle(2, 1'b1);

    // backpressure and overflow, then accept and clear
    send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0);
    chk("held_data_o", 32'(bus.data_o), 32'h11);
    idle(1, 1'b1);
    idle(1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // accept and complete on the same edge
    send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b1);
    chk("swap_data_o", 32'(bus.data_o), 32'h22);
    idle(2, 1'b1);

    // random frames with noise, gaps, backpressure and clears
    p = SP;
    for (int f = 0; f < 40; f++) begin
      bits.delete();
      nidle = $urandom_range(0, 4);
      d = W'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      for (int i = 0; i < nidle; i++) bits.push_back(1'($urandom_range(0, 1)));
      for (int i = SL - 1; i >= 0; i--) bits.push_back(p[i]);
      for (int i = W - 1; i >= 0; i--) bits.push_back(d[i]);
      bits.push_back(pb);
      for (int i = 0; i < bits.size(); i++) begin
        rdy = $urandom_range(0, 3) != 0;
        cyc(1'b1, bits[i], rdy, $urandom_range(0, 15) == 0);
        ngap = $urandom_range(0, 2);
        for (int g = 0; g < ngap; g++) cyc(1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0);
      end
    end
    idle(3, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // reset mid-frame while a word is held and overflow is set
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < SL; i++) cyc(1'b1, p[SL-1-i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bus.bit_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'hC3, 1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // counter wrap
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    mon_cnt = 16'hFFFF;
    chk("preload_count", 32'(bus.frame_count_o), 32'hFFFF);
    send_frame(8'h81, 1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("wrap_count", 32'(bus.frame_count_o), 32'h0000);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
